// File: rtl/dma_copy_if.sv
// Initiator-side view of the peripheral-block req/gnt/rvalid memory bus.
// The DMA engine uses the master modport; memory targets use the slave modport.
interface dma_copy_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dma_copy.sv
// Word-copy DMA engine: for each word it reads the source and then writes the destination,
// with one bus transaction outstanding at a time and an optional per-state wait timeout.
module dma_copy #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src,
    input  logic [31:0] dst,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    dma_copy_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] src_ptr_q, src_ptr_d;
    logic [31:0] dst_ptr_q, dst_ptr_d;
    logic [15:0] count_q, count_d;
    logic [15:0] wait_q, wait_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Byte-offset bits of the command addresses are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src[1:0], dst[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // wdata_q doubles as the data buffer: it is loaded with the read word and held for the write.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        count_d   = count_q;
        wait_d    = (state_q == IDLE) ? 16'd0 : wait_q + 16'd1;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != 16'd0) begin
                        src_ptr_d = {src[31:2], 2'b00};
                        dst_ptr_d = {dst[31:2], 2'b00};
                        count_d   = len;
                        state_d   = RD_REQ;
                        req_d     = 1'b1;
                        we_d      = 1'b0;
                        be_d      = 4'hF;
                        addr_d    = {src[31:2], 2'b00};
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (bus.gnt) begin
                    state_d = RD_WAIT;
                    req_d   = 1'b0;
                    wait_d  = 16'd0;
                end
            end
            RD_WAIT: begin
                if (bus.rvalid) begin
                    state_d = WR_REQ;
                    wdata_d = bus.rdata;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    be_d    = 4'hF;
                    addr_d  = dst_ptr_q;
                    wait_d  = 16'd0;
                end
            end
            WR_REQ: begin
                if (bus.gnt) begin
                    state_d = WR_WAIT;
                    req_d   = 1'b0;
                    wait_d  = 16'd0;
                end
            end
            WR_WAIT: begin
                if (bus.rvalid) begin
                    src_ptr_d = src_ptr_q + 32'd4;
                    dst_ptr_d = dst_ptr_q + 32'd4;
                    count_d   = count_q - 16'd1;
                    wait_d    = 16'd0;
                    if (count_q == 16'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        be_d    = 4'hF;
                        addr_d  = src_ptr_q + 32'd4;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Bus progress in the final allowed cycle wins over the abort.
        if (TO_EN && (state_q != IDLE) && (state_d == state_q) && (wait_q == TO_LAST)) begin
            state_d = IDLE;
            req_d   = 1'b0;
            wait_d  = 16'd0;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.be    = be_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: a RAM target that grants one cycle after req and
// answers one cycle after gnt, with address logging and a no-grant mode.
module tb_dma_copy;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;

    dma_copy_if bus ();

    dma_copy #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target model state
    logic        tgt_en = 1'b1;
    logic        inj_rv = 1'b0;
    logic        gnt_t = 1'b0;
    logic        rvalid_t = 1'b0;
    logic [31:0] rdata_t = '0;
    logic [31:0] mem [0:1023];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;
    logic [31:0] log_addr [0:63];
    logic        log_we [0:63];
    logic [3:0]  log_be [0:63];
    int          log_n = 0;

    assign bus.gnt    = gnt_t;
    assign bus.rvalid = rvalid_t | inj_rv;
    assign bus.rdata  = rdata_t;

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        gnt_t    <= tgt_en && bus.req && !gnt_t;
        rvalid_t <= gnt_t && bus.req;
        if (gnt_t && bus.req) begin
            if (bus.we) mem[bus.addr[11:2]] <= bus.wdata;
            else        rdata_t <= mem[bus.addr[11:2]];
            log_addr[log_n % 64] <= bus.addr;
            log_we[log_n % 64]   <= bus.we;
            log_be[log_n % 64]   <= bus.be;
            log_n <= log_n + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [9:0] idx, input logic [31:0] val);
        poke_idx = idx;
        poke_val = val;
        poke_en  = 1'b1;
        step();
        poke_en  = 1'b0;
    endtask

    // Returns one tick after the edge that samples start.
    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 300) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        tests++;
        if ({busy, done, err} !== 3'b000) begin
            fails++; $display("FAIL reset_status: got %b expected 000", {busy, done, err});
        end
        tests++;
        if ({bus.req, bus.we, bus.be, bus.addr, bus.wdata} !== 70'd0) begin
            fails++; $display("FAIL reset_bus: got req=%b we=%b be=%h addr=%h wdata=%h expected all 0",
                              bus.req, bus.we, bus.be, bus.addr, bus.wdata);
        end
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        int cyc;
        int base;
        poke(10'h000, 32'hDEADBEEF);
        poke(10'h004, 32'h0);
        base = log_n;
        issue(32'h2000, 32'h2010, 16'd1);
        tests++;
        if (busy !== 1'b1 || bus.req !== 1'b1) begin
            fails++; $display("FAIL single_busy_req: got busy=%b req=%b expected 1 1", busy, bus.req);
        end
        wait_done(cyc);
        tests++;
        if (cyc !== 6) begin
            fails++; $display("FAIL single_latency: got %0d expected 6", cyc);
        end
        tests++;
        if ({done, err, busy} !== 3'b100) begin
            fails++; $display("FAIL single_done: got done/err/busy=%b expected 100", {done, err, busy});
        end
        tests++;
        if (mem[10'h004] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_data: got %h expected DEADBEEF", mem[10'h004]);
        end
        tests++;
        if (log_addr[base % 64] !== 32'h2000 || log_addr[(base + 1) % 64] !== 32'h2010) begin
            fails++; $display("FAIL single_addrs: got %h %h expected 00002000 00002010",
                              log_addr[base % 64], log_addr[(base + 1) % 64]);
        end
        step();
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL single_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_multi_misaligned();
        int cyc;
        int base;
        logic [31:0] exp_a;
        logic        bad_be;
        for (int i = 0; i < 4; i++) poke(10'(i), 32'hC0DE0000 + 32'(i * 17));
        for (int i = 0; i < 4; i++) poke(10'(10'h040 + i), 32'h0);
        base = log_n;
        issue(32'h2003, 32'h2102, 16'd4);
        wait_done(cyc);
        tests++;
        if (cyc !== 24 || err !== 1'b0) begin
            fails++; $display("FAIL multi_latency: got %0d err=%b expected 24 err=0", cyc, err);
        end
        tests++;
        if (log_n - base !== 8) begin
            fails++; $display("FAIL multi_access_count: got %0d expected 8", log_n - base);
        end
        bad_be = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_a = ((k % 2) == 0) ? 32'h2000 + 32'(4 * (k / 2)) : 32'h2100 + 32'(4 * (k / 2));
            tests++;
            if (log_addr[(base + k) % 64] !== exp_a || log_we[(base + k) % 64] !== 1'(k % 2)) begin
                fails++; $display("FAIL multi_addr_%0d: got %h we=%b expected %h we=%0d",
                                  k, log_addr[(base + k) % 64], log_we[(base + k) % 64], exp_a, k % 2);
            end
            if (log_be[(base + k) % 64] !== 4'hF) bad_be = 1'b1;
        end
        tests++;
        if (bad_be !== 1'b0) begin
            fails++; $display("FAIL multi_be: got a byte enable other than F, expected F throughout");
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (mem[10'(10'h040 + i)] !== 32'hC0DE0000 + 32'(i * 17)) begin
                fails++; $display("FAIL multi_data_%0d: got %h expected %h",
                                  i, mem[10'(10'h040 + i)], 32'hC0DE0000 + 32'(i * 17));
            end
        end
    endtask

    task automatic test_zero_len();
        int base;
        int busy_seen;
        base = log_n;
        issue(32'h2000, 32'h2100, 16'd0);
        tests++;
        if ({done, err, busy, bus.req} !== 4'b1000) begin
            fails++; $display("FAIL zero_done: got done/err/busy/req=%b expected 1000",
                              {done, err, busy, bus.req});
        end
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy || bus.req || done) busy_seen++;
        end
        tests++;
        if (busy_seen !== 0 || log_n !== base) begin
            fails++; $display("FAIL zero_quiet: got %0d active cycles %0d accesses expected 0 0",
                              busy_seen, log_n - base);
        end
    endtask

    task automatic test_busy_start();
        int cyc;
        poke(10'h000, 32'h01234567);
        poke(10'h001, 32'h89ABCDEF);
        poke(10'h050, 32'h5A5A5A5A);
        poke(10'h060, 32'h0);
        poke(10'h061, 32'h0);
        issue(32'h2000, 32'h2180, 16'd2);
        step();
        start = 1'b1;
        src   = 32'h2000;
        dst   = 32'h2140;
        len   = 16'd7;
        step();
        start = 1'b0;
        wait_done(cyc);
        tests++;
        if (cyc + 2 !== 12 || err !== 1'b0) begin
            fails++; $display("FAIL busy_start_latency: got %0d err=%b expected 12 err=0", cyc + 2, err);
        end
        tests++;
        if (mem[10'h060] !== 32'h01234567 || mem[10'h061] !== 32'h89ABCDEF) begin
            fails++; $display("FAIL busy_start_data: got %h %h expected 01234567 89ABCDEF",
                              mem[10'h060], mem[10'h061]);
        end
        tests++;
        if (mem[10'h050] !== 32'h5A5A5A5A) begin
            fails++; $display("FAIL busy_start_ignored: got %h expected 5A5A5A5A", mem[10'h050]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        poke(10'h000, 32'hAAAA0001);
        poke(10'h001, 32'hBBBB0002);
        poke(10'h008, 32'h0);
        poke(10'h009, 32'h0);
        issue(32'h2000, 32'h2020, 16'd1);
        wait_done(cyc);
        issue(32'h2004, 32'h2024, 16'd1);
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL b2b_accept: got busy=%b expected 1", busy);
        end
        wait_done(cyc);
        tests++;
        if (cyc !== 6 || mem[10'h008] !== 32'hAAAA0001 || mem[10'h009] !== 32'hBBBB0002) begin
            fails++; $display("FAIL b2b_copy: got cyc=%0d %h %h expected 6 AAAA0001 BBBB0002",
                              cyc, mem[10'h008], mem[10'h009]);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int rc;
        tgt_en = 1'b0;
        step();
        issue(32'h2000, 32'h2100, 16'd3);
        cyc = 0;
        rc  = 0;
        while (!done && cyc < 50) begin
            if (bus.req) rc++;
            step();
            cyc++;
        end
        tests++;
        if (rc !== 8 || cyc !== 8) begin
            fails++; $display("FAIL timeout_req_cycles: got req=%0d cyc=%0d expected 8 8", rc, cyc);
        end
        tests++;
        if ({done, err, busy, bus.req} !== 4'b1100) begin
            fails++; $display("FAIL timeout_done_err: got done/err/busy/req=%b expected 1100",
                              {done, err, busy, bus.req});
        end
        step();
        tests++;
        if ({done, err} !== 2'b00) begin
            fails++; $display("FAIL timeout_pulse: got done/err=%b expected 00", {done, err});
        end
        tgt_en = 1'b1;
        poke(10'h000, 32'h7777AAAA);
        poke(10'h070, 32'h0);
        issue(32'h2000, 32'h21C0, 16'd1);
        wait_done(cyc);
        tests++;
        if ({done, err} !== 2'b10 || mem[10'h070] !== 32'h7777AAAA) begin
            fails++; $display("FAIL timeout_recover: got done/err=%b data=%h expected 10 7777AAAA",
                              {done, err}, mem[10'h070]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int cyc;
        int base;
        for (int i = 0; i < 4; i++) poke(10'(i), 32'hBEEF0000 + 32'(i));
        poke(10'h0C0, 32'h0);
        poke(10'h0C1, 32'h0);
        base = log_n;
        issue(32'h2000, 32'h2200, 16'd4);
        n = 0;
        while (!(bus.req && bus.we && (log_n - base) == 3) && n < 100) begin
            step();
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++; $display("FAIL reset_mid_reach: got no WR_REQ of word 2 within %0d cycles expected one", n);
        end
        #3 rst = 1'b0;
        #1;
        tests++;
        if ({busy, done, err, bus.req, bus.we} !== 5'b0 || bus.addr !== 32'h0 ||
            bus.wdata !== 32'h0 || bus.be !== 4'h0) begin
            fails++; $display("FAIL reset_mid_async: got busy=%b req=%b we=%b be=%h addr=%h wdata=%h expected all 0",
                              busy, bus.req, bus.we, bus.be, bus.addr, bus.wdata);
        end
        step();
        rst = 1'b1;
        step();
        inj_rv = 1'b1;
        step();
        inj_rv = 1'b0;
        step();
        tests++;
        if ({busy, done, err, bus.req} !== 4'b0) begin
            fails++; $display("FAIL reset_mid_rvalid_ignored: got busy/done/err/req=%b expected 0000",
                              {busy, done, err, bus.req});
        end
        issue(32'h2000, 32'h2300, 16'd2);
        wait_done(cyc);
        tests++;
        if (cyc !== 12 || err !== 1'b0 || mem[10'h0C0] !== 32'hBEEF0000 || mem[10'h0C1] !== 32'hBEEF0001) begin
            fails++; $display("FAIL reset_mid_fresh: got cyc=%0d err=%b %h %h expected 12 0 BEEF0000 BEEF0001",
                              cyc, err, mem[10'h0C0], mem[10'h0C1]);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        int base;
        poke(10'h3FF, 32'h11112222);
        poke(10'h000, 32'h33334444);
        poke(10'h010, 32'h0);
        poke(10'h011, 32'h0);
        base = log_n;
        issue(32'hFFFFFFFC, 32'h3040, 16'd2);
        wait_done(cyc);
        tests++;
        if (log_addr[(base + 2) % 64] !== 32'h0 || log_addr[base % 64] !== 32'hFFFFFFFC) begin
            fails++; $display("FAIL wrap_addr: got %h then %h expected FFFFFFFC then 00000000",
                              log_addr[base % 64], log_addr[(base + 2) % 64]);
        end
        tests++;
        if (cyc !== 12 || err !== 1'b0) begin
            fails++; $display("FAIL wrap_done: got cyc=%0d err=%b expected 12 0", cyc, err);
        end
        tests++;
        if (mem[10'h010] !== 32'h11112222 || mem[10'h011] !== 32'h33334444) begin
            fails++; $display("FAIL wrap_data: got %h %h expected 11112222 33334444",
                              mem[10'h010], mem[10'h011]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        rst   = 1'b1;
        test_reset();
        test_single();
        test_multi_misaligned();
        test_zero_len();
        test_busy_start();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
